// File: rtl/pipe_latch.sv
`default_nettype none
// ============================================================================
// Module   : pipe_latch
// Purpose  : Handshaked pipeline register with flush, back-pressure and a
//            saturating stall counter. Define PIPE_LATCH_SKID_EN to add a
//            skid entry (2-deep, registered in_ready).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_latch #(
    parameter int DATA_W = 71,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              drain;

`ifdef PIPE_LATCH_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // Depends only on a flop (and reset), so out_ready never reaches in_ready.
    assign in_ready = !rst && !skid_valid_q;
`else
    assign in_ready = !rst && (!out_valid_q || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        stall_cnt_d = stall_cnt_q;
`ifdef PIPE_LATCH_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
`endif

        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            out_valid_d = 1'b0;
`ifdef PIPE_LATCH_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
`ifdef PIPE_LATCH_SKID_EN
            if (skid_valid_q) begin
                if (out_ready) begin
                    out_data_d   = skid_data_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end else if (accept && out_valid_q && !out_ready) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else
`endif
            if (accept) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else if (drain) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            stall_cnt_q <= '0;
`ifdef PIPE_LATCH_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_LATCH_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_latch
// Purpose  : Self-checking bench for pipe_latch (either build) against a
//            queue-based model, plus a CNT_W=4 saturation instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_latch;

    localparam int DW   = 71;
    localparam int CW   = 16;
    localparam int MAXC = 65535;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    logic          s_rst, s_flush, s_in_valid, s_out_ready;
    logic [7:0]    s_in_data;
    logic          s_in_ready, s_out_valid;
    logic [7:0]    s_out_data;
    logic [3:0]    s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_latch #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_latch #(.DATA_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    // Reference model: FIFO of held payloads plus a saturating counter.
    logic [DW-1:0] mq[$];
    int unsigned   mcnt = 0;

    function automatic bit m_ready();
        if (rst) return 1'b0;
`ifdef PIPE_LATCH_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcnt <= 0;
        end else begin
            if (mq.size() != 0 && !out_ready && mcnt < MAXC) mcnt <= mcnt + 1;
            if (flush) begin
                mq.delete();
            end else if (in_valid && m_ready()) begin
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                mq.push_back(in_data);
            end else if (mq.size() != 0 && out_ready) begin
                void'(mq.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {127'b0, in_ready}, {127'b0, m_ready()});
            check("out_valid", {127'b0, out_valid}, {127'b0, mq.size() != 0});
            if (mq.size() != 0) check("out_data", {57'b0, out_data}, {57'b0, mq[0]});
            check("stall_cnt", {112'b0, stall_cnt}, 128'(mcnt));
        end
    end

    task automatic step(input bit r, input bit f, input bit iv, input logic [DW-1:0] d, input bit ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [CW-1:0] s0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = DW'(12'h0AA); out_ready = 1'b0;
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;

        // Reset held two cycles with a valid input pending
        step(1, 0, 1, DW'(12'h0AA), 0);
        chk_en = 1'b1;
        step(1, 0, 1, DW'(12'h0AA), 0);
        step(0, 0, 0, '0, 1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_data", {57'b0, out_data}, 128'd0);
        check("rst_stall_cnt", {112'b0, stall_cnt}, 128'd0);
        check("rst_in_ready", {127'b0, in_ready}, 128'd1);

        // Streaming 0x001..0x010, one-cycle latency, no gaps
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, DW'(i), 1);
            check("stream_data", {57'b0, out_data}, 128'(i));
        end
        step(0, 0, 0, '0, 1);
        check("stream_stall", {112'b0, stall_cnt}, 128'd0);

        // Stall: A held, B offered with out_ready low
        step(0, 0, 1, DW'(12'h0A1), 0);
        s0 = stall_cnt;
`ifndef PIPE_LATCH_SKID_EN
        in_data = DW'(12'h0B2);
        #1;
        check("full_in_ready", {127'b0, in_ready}, 128'd0);
`endif
        step(0, 0, 1, DW'(12'h0B2), 0);
`ifdef PIPE_LATCH_SKID_EN
        check("skid_in_ready", {127'b0, in_ready}, 128'd0);
`endif
        check("stall_hold_a", {57'b0, out_data}, 128'h0A1);
        step(0, 0, 1, DW'(12'h0B2), 0);
        step(0, 0, 1, DW'(12'h0B2), 0);
        check("stall_cnt3", {112'b0, stall_cnt}, 128'(s0) + 128'd3);
        step(0, 0, 1, DW'(12'h0C3), 1);
`ifdef PIPE_LATCH_SKID_EN
        check("release_b", {57'b0, out_data}, 128'h0B2);
`else
        check("release_c", {57'b0, out_data}, 128'h0C3);
`endif
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);

        // Flush with all entries full and a payload offered
        step(0, 0, 1, DW'(12'h101), 0);
        step(0, 0, 1, DW'(12'h102), 0);
        s0 = stall_cnt;
        step(0, 1, 1, DW'(12'h055), 1);
        check("flush_out_valid", {127'b0, out_valid}, 128'd0);
        check("flush_stall", {112'b0, stall_cnt}, 128'(s0));
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, '0, 1);
            check("flush_empty", {127'b0, out_valid}, 128'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1, rnd_data(), $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);

        // Saturation on the CNT_W=4 instance
        s_rst = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 1);
        check("sat_cnt", {124'b0, s_stall_cnt}, 128'd15);
        check("sat_data", {120'b0, s_out_data}, 128'h5A);
        s_rst = 1'b1;
        step(0, 0, 0, '0, 1);
        check("sat_rst", {124'b0, s_stall_cnt}, 128'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
